// File: rtl/prog_counter.sv
// prog_counter: program counter and fetch sequencer (IDLE/RUN/DONE), branch via external target LUT.
// Latency: Start, branch and increment all land on ProgCtr on the sampling edge; LutPointer is combinational.
// Backpressure: StallReq holds ProgCtr for the cycle while CycleCount keeps counting; Start is ignored in RUN.
//
// Ports:
//   clk, rst_n         core clock (rising edge), asynchronous active-low reset
//   Start, ProgSel     begin program ProgSel (taken in IDLE or DONE only)
//   StallReq           hold PC this cycle
//   HaltReq            current instruction is halt (wins over BranchTaken)
//   BranchTaken        current instruction is a taken branch
//   InstrLutIdx        branch-target index of the current instruction
//   absaddress         target returned by the lookup table for LutPointer
//   LutPointer         index to the lookup table (InstrLutIdx in RUN, else 0)
//   ProgCtr            current instruction address
//   InstrValid         high only in RUN
//   Done, Fault        program finished; Fault marks a run past MAX_ADDR
//   CycleCount         RUN cycles since last Start, saturating
module prog_counter #(
  parameter logic [9:0] PROG0_START = 10'd0,
  parameter logic [9:0] PROG1_START = 10'd128,
  parameter logic [9:0] PROG2_START = 10'd256,
  parameter logic [9:0] PROG3_START = 10'd384,
  parameter logic [9:0] MAX_ADDR    = 10'd1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Start,
  input  logic [1:0]  ProgSel,
  input  logic        StallReq,
  input  logic        HaltReq,
  input  logic        BranchTaken,
  input  logic [3:0]  InstrLutIdx,
  input  logic [9:0]  absaddress,
  output logic [3:0]  LutPointer,
  output logic [9:0]  ProgCtr,
  output logic        InstrValid,
  output logic        Done,
  output logic        Fault,
  output logic [15:0] CycleCount
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [9:0]  pc_nxt;
  logic        done_nxt;
  logic        fault_nxt;
  logic [15:0] cnt_nxt;
  logic [9:0]  start_addr;

  always_comb begin
    start_addr = PROG0_START;
    case (ProgSel)
      2'd0: start_addr = PROG0_START;
      2'd1: start_addr = PROG1_START;
      2'd2: start_addr = PROG2_START;
      2'd3: start_addr = PROG3_START;
      default: start_addr = PROG0_START;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ProgCtr    <= 10'd0;
      Done       <= 1'b0;
      Fault      <= 1'b0;
      CycleCount <= 16'd0;
    end else begin
      state      <= state_nxt;
      ProgCtr    <= pc_nxt;
      Done       <= done_nxt;
      Fault      <= fault_nxt;
      CycleCount <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = ProgCtr;
    done_nxt  = Done;
    fault_nxt = Fault;
    cnt_nxt   = CycleCount;

    case (state)
      RUN: begin
        // Every RUN cycle counts, including stall, halt and the faulting cycle.
        if (CycleCount != 16'hFFFF) begin
          cnt_nxt = CycleCount + 16'd1;
        end
        if (StallReq) begin
          pc_nxt = ProgCtr;
        end else if (HaltReq) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end else if (BranchTaken) begin
          // Target loaded as-is, even beyond MAX_ADDR; the next increment faults.
          pc_nxt = absaddress;
        end else if (ProgCtr >= MAX_ADDR) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
          fault_nxt = 1'b1;
        end else begin
          pc_nxt = ProgCtr + 10'd1;
        end
      end
      default: begin
        // IDLE and DONE share restart behaviour; StallReq has no effect here.
        if (Start) begin
          state_nxt = RUN;
          pc_nxt    = start_addr;
          done_nxt  = 1'b0;
          fault_nxt = 1'b0;
          cnt_nxt   = 16'd0;
        end
      end
    endcase
  end

  assign InstrValid = (state == RUN);
  assign LutPointer = (state == RUN) ? InstrLutIdx : 4'd0;

endmodule
